div32_iter: RTL and testbench

- Iterative signed 32-bit integer divider for the execute stage; sits beside the 32-bit adder/compare unit.
- Its quotient and remainder feed the same writeback mux as the adder sum.
- Uses one restoring-division step per clock; the processor stalls on busy.
- Exceptions (divide-by-zero, overflow) are flagged alongside the result, in the same way the adder reports ovf.

---
 rtl/div32_iter_pkg.sv | 17 +
 rtl/div_sub_step.sv | 26 ++
 rtl/div32_iter.sv | 153 +++++++++++++++
 tb/tb_div32_iter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/div32_iter_pkg.sv
// Shared constants for the iterative signed divider: default width,
// FSM state encoding and the most-negative 32-bit operand.
// Imported by div32_iter and div_sub_step.
package div32_iter_pkg;

    localparam int DIV_WIDTH = 32;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] ZERO = 2'd3;

    // Most-negative dividend; together with a -1 divisor it overflows.
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage : div32_iter_pkg

// File: rtl/div_sub_step.sv
// One restoring-division step: trial subtract of D from the shifted partial
// remainder, keep the difference and emit a 1 if it did not borrow.
// Purely combinational (zero latency); no flow control.
// Ports: r_shifted (WIDTH+1) and d (WIDTH) in; r_next (WIDTH) and q_bit out.
module div_sub_step
    import div32_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r_shifted,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    // One extra bit beyond WIDTH+1 so the borrow-out is an exact sign.
    logic [WIDTH+1:0] trial;

    always_comb begin
        trial  = {1'b0, r_shifted} - {2'b00, d};
        q_bit  = ~trial[WIDTH+1];
        // Either branch is below D, so it always fits in WIDTH bits.
        r_next = q_bit ? trial[WIDTH-1:0] : r_shifted[WIDTH-1:0];
    end

endmodule : div_sub_step

// File: rtl/div32_iter.sv
// Iterative signed divider (restoring, one quotient bit per clock).
// Latency: WIDTH+1 clocks from accepted start to result_rdy; 1 clock for divide-by-zero.
// Backpressure: busy high while in flight; div_start ignored while busy.
// Ports: clock/reset_n; div_start, dividend, divisor in; busy, result_rdy,
//        quotient, remainder, div_by_zero, ovf out (results held until next completion).
module div32_iter
    import div32_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             result_rdy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;

    // Magnitude datapath and operation context
    logic [WIDTH-1:0] q_q;        // |dividend| shifting out, quotient bits shifting in
    logic [WIDTH-1:0] d_q;        // |divisor| (unsigned, so |INT_MIN| is representable)
    logic [WIDTH-1:0] r_q;        // partial remainder
    logic [WIDTH-1:0] orig_q;     // original dividend, returned on divide-by-zero
    logic [CNT_W-1:0] cnt_q;
    logic             sign_q_q;   // quotient sign
    logic             sign_r_q;   // remainder sign (follows dividend)
    logic             ovf_case_q;

    // Registered results
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             dbz_q, ovf_q, rdy_q;

    // One iteration
    logic [WIDTH:0]   r_shifted;
    logic [WIDTH-1:0] r_next;
    logic             q_bit;

    assign r_shifted = {r_q, q_q[WIDTH-1]};

    div_sub_step #(.WIDTH(WIDTH)) u_step (
        .r_shifted (r_shifted),
        .d         (d_q),
        .r_next    (r_next),
        .q_bit     (q_bit)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (div_start) begin
                    state_d = (divisor == '0) ? ZERO : ITER;
                end
            end
            ITER: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            ZERO:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy        = (state_q != IDLE);
        result_rdy  = rdy_q;
        quotient    = quotient_q;
        remainder   = remainder_q;
        div_by_zero = dbz_q;
        ovf         = ovf_q;
    end

    // Datapath and result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            orig_q      <= '0;
            cnt_q       <= '0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            ovf_case_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (div_start) begin
                        sign_q_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r_q   <= dividend[WIDTH-1];
                        q_q        <= dividend[WIDTH-1] ? -dividend : dividend;
                        d_q        <= divisor[WIDTH-1]  ? -divisor  : divisor;
                        r_q        <= '0;
                        cnt_q      <= '0;
                        orig_q     <= dividend;
                        ovf_case_q <= (dividend == INT_MIN) && (divisor == '1);
                    end
                end
                ITER: begin
                    q_q   <= {q_q[WIDTH-2:0], q_bit};
                    r_q   <= r_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    // INT_MIN / -1: magnitude 2^31 with positive sign wraps
                    // naturally to INT_MIN with zero remainder.
                    quotient_q  <= sign_q_q ? -q_q : q_q;
                    remainder_q <= sign_r_q ? -r_q : r_q;
                    dbz_q       <= 1'b0;
                    ovf_q       <= ovf_case_q;
                    rdy_q       <= 1'b1;
                end
                ZERO: begin
                    quotient_q  <= '0;
                    remainder_q <= orig_q;
                    dbz_q       <= 1'b1;
                    ovf_q       <= 1'b0;
                    rdy_q       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule : div32_iter

// File: tb/tb_div32_iter.sv
module tb_div32_iter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        div_start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, result_rdy, div_by_zero, ovf;
    logic [31:0] quotient, remainder;

    int err_cnt = 0;
    int chk_cnt = 0;

    div32_iter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .div_start   (div_start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .result_rdy  (result_rdy),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .ovf         (ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after the accepting edge k. Returns at the negedge of the
    // result_rdy cycle; lat = n where result_rdy is high after edge k+n.
    task automatic wait_done(input string tag, output int lat, output int bsy);
        bit seen = 0;
        lat = 0;
        bsy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (result_rdy) begin
                seen = 1;
                break;
            end
            if (busy) bsy++;
            @(posedge clock);
            lat++;
        end
        chk({tag, " done seen"}, 32'(seen), 32'd1);
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        dividend  = a;
        divisor   = b;
        div_start = 1'b1;
        @(posedge clock);
        #1 div_start = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [31:0] q, input logic [31:0] r,
                             input logic dz, input logic ov);
        chk({tag, " quotient"},  quotient,  q);
        chk({tag, " remainder"}, remainder, r);
        chk({tag, " dbz"},       32'(div_by_zero), 32'(dz));
        chk({tag, " ovf"},       32'(ovf),  32'(ov));
        chk({tag, " busy@rdy"},  32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bsy, n_rdy;

        // Reset state
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rdy",  32'(result_rdy), 32'd0);
        chk("reset quot", quotient, 32'd0);
        chk("reset rem",  remainder, 32'd0);
        chk("reset flags", {30'd0, div_by_zero, ovf}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // 100 / 7
        start_op(32'd100, 32'd7);
        wait_done("100/7", lat, bsy);
        chk("100/7 latency", 32'(lat), 32'd33);
        chk("100/7 busy cycles", 32'(bsy), 32'd33);
        check_res("100/7", 32'd14, 32'd2, 1'b0, 1'b0);
        @(negedge clock);
        chk("rdy single pulse", 32'(result_rdy), 32'd0);
        chk("quot held", quotient, 32'd14);

        // Signed cases
        start_op(32'hFFFF_FF9C, 32'd7);
        wait_done("-100/7", lat, bsy);
        check_res("-100/7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        start_op(32'd7, 32'hFFFF_FFFE);
        wait_done("7/-2", lat, bsy);
        check_res("7/-2", 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);

        // Divide by zero
        start_op(32'h1234_5678, 32'd0);
        wait_done("div0", lat, bsy);
        chk("div0 latency", 32'(lat), 32'd1);
        chk("div0 busy cycles", 32'(bsy), 32'd1);
        check_res("div0", 32'd0, 32'h1234_5678, 1'b1, 1'b0);

        // Overflow and INT_MIN / 1
        start_op(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("ovf", lat, bsy);
        check_res("ovf", 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        start_op(32'h8000_0000, 32'd1);
        wait_done("min/1", lat, bsy);
        check_res("min/1", 32'h8000_0000, 32'd0, 1'b0, 1'b0);

        // Start pulse while busy is ignored
        start_op(32'd100, 32'd7);
        repeat (9) @(negedge clock);
        dividend  = 32'd50;
        divisor   = 32'd5;
        div_start = 1'b1;
        @(negedge clock);
        div_start = 1'b0;
        wait_done("busy-ign", lat, bsy);
        chk("busy-ign latency", 32'(lat + 10), 32'd33);
        check_res("busy-ign", 32'd14, 32'd2, 1'b0, 1'b0);

        // Back-to-back: start in the result_rdy cycle
        dividend  = 32'd9;
        divisor   = 32'd3;
        div_start = 1'b1;
        @(posedge clock);
        #1 div_start = 1'b0;
        wait_done("b2b", lat, bsy);
        chk("b2b latency", 32'(lat), 32'd33);
        check_res("b2b", 32'd3, 32'd0, 1'b0, 1'b0);

        // Reset mid-operation
        start_op(32'd100, 32'd7);
        repeat (15) @(negedge clock);
        chk("pre-reset busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst rdy",  32'(result_rdy), 32'd0);
        chk("midrst quot", quotient, 32'd0);
        chk("midrst rem",  remainder, 32'd0);
        chk("midrst flags", {30'd0, div_by_zero, ovf}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        n_rdy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (result_rdy) n_rdy++;
        end
        chk("midrst no rdy", 32'(n_rdy), 32'd0);
        start_op(32'd100, 32'd7);
        wait_done("post-rst", lat, bsy);
        chk("post-rst latency", 32'(lat), 32'd33);
        check_res("post-rst", 32'd14, 32'd2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_div32_iter
